param_divider: RTL and testbench

PARAM_DIVIDER -- requirements
Module: param_divider

---
 rtl/param_divider.sv | 154 +++++++++++++++
 tb/tb_param_divider.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, MSB first.
// Define DIV_SIGNED_EN to add two's-complement mode selected by signed_op.
module param_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_den_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_num_mag;
  logic [WIDTH-1:0] w_den_mag;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_part_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_quo_f;
  logic [WIDTH-1:0] w_rem_f;
  logic             w_unused;

  assign w_accept   = start && (r_state != S_CALC);
  assign w_den_zero = (den == '0);
  assign w_last     = (r_cnt == CW'(1));

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_num_neg;
  logic w_den_neg;

  assign w_num_neg = signed_op & num[WIDTH-1];
  assign w_den_neg = signed_op & den[WIDTH-1];
  assign w_num_mag = w_num_neg ? -num : num;
  assign w_den_mag = w_den_neg ? -den : den;
  assign w_quo_f   = r_neg_q ? -w_quo_n : w_quo_n;
  assign w_rem_f   = r_neg_r ? -w_part_n : w_part_n;
  assign w_unused  = w_diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_num_neg ^ w_den_neg;
      r_neg_r <= w_num_neg;
    end
  end
`else
  assign w_num_mag = num;
  assign w_den_mag = den;
  assign w_quo_f   = w_quo_n;
  assign w_rem_f   = w_part_n;
  assign w_unused  = ^{signed_op, w_diff[WIDTH]};
`endif

  // Partial remainder widened by one bit so a large divisor never wraps.
  assign w_sh     = {r_part, r_dvd[WIDTH-1]};
  assign w_diff   = {1'b0, w_sh} - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_part_n = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign w_quo_n  = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start) w_next = w_den_zero ? S_FIN : S_CALC;
      S_CALC:
        if (w_last) w_next = S_FIN;
      S_FIN:
        if (start) w_next = w_den_zero ? S_FIN : S_CALC;
        else       w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CALC);
    done = (r_state == S_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_part <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= CW'(WIDTH);
      r_part <= '0;
      r_dvd  <= w_num_mag;
      r_dvs  <= w_den_mag;
      if (w_den_zero) begin
        r_quo <= '1;
        r_rem <= num;
        r_dbz <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_cnt  <= r_cnt - CW'(1);
      r_part <= w_part_n;
      r_dvd  <= w_quo_n;
      if (w_last) begin
        r_quo <= w_quo_f;
        r_rem <= w_rem_f;
        r_dbz <= 1'b0;
      end
    end
  end

  assign quo         = r_quo;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_param_divider.sv
// Table-driven bench for param_divider (WIDTH=32) with a result scoreboard.
// Expected signed-mode results follow DIV_SIGNED_EN when it is defined.
module tb_param_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] num;
  logic [31:0] den;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_by_zero;

  param_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num(num),
    .den(den),
    .signed_op(signed_op),
    .busy(busy),
    .done(done),
    .quo(quo),
    .rem(rem),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quo", quo, e.q);
        chk("rem", rem, e.r);
        chk("div_by_zero", div_by_zero, e.z);
      end
    end
  end

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end while (!done && n < 100);
  endtask

  task automatic run_vec(input vec_t v);
    int n, nb;
    exp_t e;
    @(negedge clk);
    num = v.n;
    den = v.d;
    signed_op = v.s;
    start = 1'b1;
    e.q = v.q;
    e.r = v.r;
    e.z = v.z;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    chk("latency", 64'(n), 64'(v.lat));
    chk("busy_cycles", 64'(nb), 64'(v.lat - 1));
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("quo_hold", quo, v.q);
  endtask

  task automatic count_dones(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int n, nb, cnt;
    exp_t e;

    vecs[0] = '{32'd90, 32'd4, 1'b0, 32'd22, 32'd2, 1'b0, 33};
    vecs[1] = '{32'd7, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd7, 1'b1, 1};
`ifdef DIV_SIGNED_EN
    vecs[2] = '{32'hFFFFFFF9, 32'd2, 1'b1,
                32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
                32'h80000000, 32'd0, 1'b0, 33};
`else
    vecs[2] = '{32'hFFFFFFF9, 32'd2, 1'b1,
                32'h7FFFFFFC, 32'd1, 1'b0, 33};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
                32'd0, 32'h80000000, 1'b0, 33};
`endif
    vecs[3] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33};
    vecs[4] = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                32'd1, 32'd0, 1'b0, 33};
    vecs[7] = '{32'hFFFFFFF9, 32'd0, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
    vecs[8] = '{32'hFFFFFFFE, 32'd3, 1'b0,
                32'h55555554, 32'd2, 1'b0, 33};
    vecs[9] = '{32'h12345678, 32'd1, 1'b0,
                32'h12345678, 32'd0, 1'b0, 33};

    rst = 1'b1;
    start = 1'b0;
    num = '0;
    den = '0;
    signed_op = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quo", quo, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // start pulsed mid-calculation must not disturb the running divide
    @(negedge clk);
    num = 32'd9;
    den = 32'd3;
    start = 1'b1;
    e = '{32'd3, 32'd0, 1'b0};
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    num = 32'd8;
    den = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    chk("ignore_latency", 64'(n), 64'd23);
    count_dones(40, cnt);
    chk("ignore_extra_done", 64'(cnt), 64'd0);

    // asynchronous reset in the middle of CALC aborts silently
    @(negedge clk);
    num = 32'd90;
    den = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quo", quo, 32'd0);
    chk("abort_rem", rem, 32'd0);
    chk("abort_dbz", div_by_zero, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    count_dones(40, cnt);
    chk("abort_no_done", 64'(cnt), 64'd0);
    run_vec('{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 33});

    // start held through FIN chains the next divide with no idle cycle
    @(negedge clk);
    num = 32'd90;
    den = 32'd4;
    start = 1'b1;
    e = '{32'd22, 32'd2, 1'b0};
    sb.push_back(e);
    @(posedge clk);
    #1;
    num = 32'd100;
    den = 32'd7;
    e = '{32'd14, 32'd2, 1'b0};
    sb.push_back(e);
    wait_done(n, nb);
    chk("b2b_first_latency", 64'(n), 64'd33);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    chk("b2b_spacing", 64'(n), 64'd33);
    chk("b2b_busy", 64'(nb), 64'd32);

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
